// File: rtl/idx2cloud_stream_pkg.sv
// Shared widths, state encoding and point record for the depth-to-cloud back-projection engine.
package idx2cloud_stream_pkg;

    localparam int DATA_DEPTH_BW = 16;
    localparam int MUL           = 8;
    localparam int CLOUD_BW      = 32;
    localparam int H_SIZE_BW     = 11;
    localparam int V_SIZE_BW     = 10;
    localparam int CX_BW         = H_SIZE_BW + MUL;
    localparam int CY_BW         = V_SIZE_BW + MUL;
    localparam int INV_W         = 24;
    localparam int INV_FRAC      = 20;

    localparam int DEPTH_W = DATA_DEPTH_BW;
    localparam int FRAC_W  = MUL;
    localparam int OUT_W   = CLOUD_BW;

    // Signed intermediate widths: offset, offset*depth, offset*depth*reciprocal.
    localparam int DX_W = CX_BW + 1;
    localparam int DY_W = CY_BW + 1;
    localparam int PX_W = DX_W + DEPTH_W + 1;
    localparam int PY_W = DY_W + DEPTH_W + 1;
    localparam int QX_W = PX_W + INV_W + 1;
    localparam int QY_W = PY_W + INV_W + 1;

    typedef logic signed [DX_W-1:0] dx_t;
    typedef logic signed [DY_W-1:0] dy_t;
    typedef logic signed [PX_W-1:0] px_t;
    typedef logic signed [PY_W-1:0] py_t;
    typedef logic signed [QX_W-1:0] qx_t;
    typedef logic signed [QY_W-1:0] qy_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } raster_state_t;

    typedef struct packed {
        logic [OUT_W-1:0]     x;
        logic [OUT_W-1:0]     y;
        logic [OUT_W-1:0]     z;
        logic [H_SIZE_BW-1:0] idx_x;
        logic [V_SIZE_BW-1:0] idx_y;
        logic                 invalid;
    } cloud_pt_t;

    function automatic logic [OUT_W-1:0] depth_to_z(input logic [DEPTH_W-1:0] d);
        return {{(OUT_W - DEPTH_W - FRAC_W){1'b0}}, d, {FRAC_W{1'b0}}};
    endfunction

endpackage

// File: rtl/idx2cloud_raster_ctr.sv
// Frame sequencer for idx2cloud_stream: IDLE/RUN/DRAIN FSM, raster x/y counters,
// sample handshake and end-of-frame pulse.
module idx2cloud_raster_ctr
    import idx2cloud_stream_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 start,
    input  logic                 valid,
    input  logic                 pipe_en,
    input  logic                 drain_done,
    input  logic [H_SIZE_BW-1:0] width,
    input  logic [V_SIZE_BW-1:0] height,
    output logic                 ready,
    output logic                 accept,
    output logic [H_SIZE_BW-1:0] cur_x,
    output logic [V_SIZE_BW-1:0] cur_y,
    output logic                 frame_done,
    output logic                 busy
);

    raster_state_t state;
    logic          last_x;
    logic          last_y;

    assign ready  = (state == ST_RUN) && pipe_en;
    assign accept = valid && ready;
    assign last_x = (cur_x == width - H_SIZE_BW'(1));
    assign last_y = (cur_y == height - V_SIZE_BW'(1));

    // The frame ends once the bottom-right pixel is accepted; DRAIN waits for the pipe to empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        cur_x <= '0;
                        cur_y <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last_x) begin
                            cur_x <= '0;
                            if (last_y) begin
                                cur_y <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                cur_y <= cur_y + V_SIZE_BW'(1);
                            end
                        end else begin
                            cur_x <= cur_x + H_SIZE_BW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/idx2cloud_stream.sv
// Raster-scan depth-to-cloud back-projection engine with a 4-stage stallable pipeline.
// Define IDX2CLOUD_RANGE_CHECK_EN to also flag depths outside [r_depth_min, r_depth_max].
module idx2cloud_stream
    import idx2cloud_stream_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DEPTH_W-1:0]   i_depth,
    input  logic [H_SIZE_BW-1:0] r_width,
    input  logic [V_SIZE_BW-1:0] r_height,
    input  logic [CX_BW-1:0]     r_cx,
    input  logic [CY_BW-1:0]     r_cy,
    input  logic [INV_W-1:0]     r_inv_fx,
    input  logic [INV_W-1:0]     r_inv_fy,
    input  logic [DEPTH_W-1:0]   r_depth_min,
    input  logic [DEPTH_W-1:0]   r_depth_max,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_W-1:0]     o_cloud_x,
    output logic [OUT_W-1:0]     o_cloud_y,
    output logic [OUT_W-1:0]     o_cloud_z,
    output logic [H_SIZE_BW-1:0] o_idx_x,
    output logic [V_SIZE_BW-1:0] o_idx_y,
    output logic                 o_invalid,
    output logic                 o_frame_done,
    output logic                 o_busy
);

    logic [3:0]           pipe_v;
    logic                 pipe_en;
    logic                 accept;
    logic                 drain_done;
    logic [H_SIZE_BW-1:0] cur_x;
    logic [V_SIZE_BW-1:0] cur_y;
    logic                 depth_bad;

    logic [DEPTH_W-1:0]   s1_d, s2_d, s3_d;
    logic [H_SIZE_BW-1:0] s1_ix, s2_ix, s3_ix;
    logic [V_SIZE_BW-1:0] s1_iy, s2_iy, s3_iy;
    logic                 s1_bad, s2_bad, s3_bad;
    dx_t                  s1_dx;
    dy_t                  s1_dy;
    px_t                  s2_px;
    py_t                  s2_py;
    qx_t                  s3_qx;
    qy_t                  s3_qy;
    qx_t                  qx_shift;
    qy_t                  qy_shift;
    cloud_pt_t            s4_next;
    cloud_pt_t            s4_pt;
    logic                 unused_shift_hi;

    // The whole pipe advances together; a held output point freezes every stage behind it.
    assign pipe_en    = !pipe_v[3] || i_ready;
    assign drain_done = (pipe_v[2:0] == 3'b000) && pipe_en;

    idx2cloud_raster_ctr u_raster_ctr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .start      (i_start),
        .valid      (i_valid),
        .pipe_en    (pipe_en),
        .drain_done (drain_done),
        .width      (r_width),
        .height     (r_height),
        .ready      (o_ready),
        .accept     (accept),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .frame_done (o_frame_done),
        .busy       (o_busy)
    );

`ifdef IDX2CLOUD_RANGE_CHECK_EN
    always_comb begin
        depth_bad = (i_depth == '0);
        if ((i_depth < r_depth_min) || (i_depth > r_depth_max)) begin
            depth_bad = 1'b1;
        end
    end
`else
    logic unused_range;
    assign unused_range = ^{r_depth_min, r_depth_max};
    always_comb begin
        depth_bad = (i_depth == '0);
    end
`endif

    // Floor division by 2^INV_FRAC, then keep the low OUT_W bits; invalid points are zeroed.
    always_comb begin
        qx_shift          = s3_qx >>> INV_FRAC;
        qy_shift          = s3_qy >>> INV_FRAC;
        s4_next.x         = s3_bad ? '0 : qx_shift[OUT_W-1:0];
        s4_next.y         = s3_bad ? '0 : qy_shift[OUT_W-1:0];
        s4_next.z         = s3_bad ? '0 : depth_to_z(s3_d);
        s4_next.idx_x     = s3_ix;
        s4_next.idx_y     = s3_iy;
        s4_next.invalid   = s3_bad;
    end

    assign unused_shift_hi = ^{qx_shift[QX_W-1:OUT_W], qy_shift[QY_W-1:OUT_W]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_v <= '0;
            s1_dx  <= '0;
            s1_dy  <= '0;
            s1_d   <= '0;
            s1_ix  <= '0;
            s1_iy  <= '0;
            s1_bad <= 1'b0;
            s2_px  <= '0;
            s2_py  <= '0;
            s2_d   <= '0;
            s2_ix  <= '0;
            s2_iy  <= '0;
            s2_bad <= 1'b0;
            s3_qx  <= '0;
            s3_qy  <= '0;
            s3_d   <= '0;
            s3_ix  <= '0;
            s3_iy  <= '0;
            s3_bad <= 1'b0;
            s4_pt  <= '0;
        end else if (pipe_en) begin
            pipe_v <= {pipe_v[2:0], accept};

            s1_dx  <= $signed({1'b0, cur_x, {FRAC_W{1'b0}}}) - $signed({1'b0, r_cx});
            s1_dy  <= $signed({1'b0, cur_y, {FRAC_W{1'b0}}}) - $signed({1'b0, r_cy});
            s1_d   <= i_depth;
            s1_ix  <= cur_x;
            s1_iy  <= cur_y;
            s1_bad <= depth_bad;

            s2_px  <= px_t'(s1_dx) * px_t'($signed({1'b0, s1_d}));
            s2_py  <= py_t'(s1_dy) * py_t'($signed({1'b0, s1_d}));
            s2_d   <= s1_d;
            s2_ix  <= s1_ix;
            s2_iy  <= s1_iy;
            s2_bad <= s1_bad;

            s3_qx  <= qx_t'(s2_px) * qx_t'($signed({1'b0, r_inv_fx}));
            s3_qy  <= qy_t'(s2_py) * qy_t'($signed({1'b0, r_inv_fy}));
            s3_d   <= s2_d;
            s3_ix  <= s2_ix;
            s3_iy  <= s2_iy;
            s3_bad <= s2_bad;

            s4_pt  <= s4_next;
        end
    end

    assign o_valid   = pipe_v[3];
    assign o_cloud_x = s4_pt.x;
    assign o_cloud_y = s4_pt.y;
    assign o_cloud_z = s4_pt.z;
    assign o_idx_x   = s4_pt.idx_x;
    assign o_idx_y   = s4_pt.idx_y;
    assign o_invalid = s4_pt.invalid;

endmodule

// File: tb/tb_idx2cloud_stream.sv
// Self-checking bench for idx2cloud_stream: randomized streams against an arithmetic reference model.
// Honours IDX2CLOUD_RANGE_CHECK_EN for the expected depth-window behaviour.
module tb_idx2cloud_stream;
    import idx2cloud_stream_pkg::*;

    typedef struct packed {
        logic [OUT_W-1:0]     x;
        logic [OUT_W-1:0]     y;
        logic [OUT_W-1:0]     z;
        logic [H_SIZE_BW-1:0] ix;
        logic [V_SIZE_BW-1:0] iy;
        logic                 inv;
    } pt_t;

    logic                 clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_start;
    logic                 i_valid;
    logic                 o_ready;
    logic [DEPTH_W-1:0]   i_depth;
    logic [H_SIZE_BW-1:0] r_width;
    logic [V_SIZE_BW-1:0] r_height;
    logic [CX_BW-1:0]     r_cx;
    logic [CY_BW-1:0]     r_cy;
    logic [INV_W-1:0]     r_inv_fx;
    logic [INV_W-1:0]     r_inv_fy;
    logic [DEPTH_W-1:0]   r_depth_min;
    logic [DEPTH_W-1:0]   r_depth_max;
    logic                 o_valid;
    logic                 i_ready;
    logic [OUT_W-1:0]     o_cloud_x, o_cloud_y, o_cloud_z;
    logic [H_SIZE_BW-1:0] o_idx_x;
    logic [V_SIZE_BW-1:0] o_idx_y;
    logic                 o_invalid;
    logic                 o_frame_done;
    logic                 o_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [DEPTH_W-1:0] pix_depth[$];
    pt_t                out_q[$];
    int                 acc_cyc, out_cyc, done_cnt, hold_err, extra_out;
    bit                 timed_out;

    always #5 clk = ~clk;

    idx2cloud_stream dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_depth      (i_depth),
        .r_width      (r_width),
        .r_height     (r_height),
        .r_cx         (r_cx),
        .r_cy         (r_cy),
        .r_inv_fx     (r_inv_fx),
        .r_inv_fy     (r_inv_fy),
        .r_depth_min  (r_depth_min),
        .r_depth_max  (r_depth_max),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_cloud_x    (o_cloud_x),
        .o_cloud_y    (o_cloud_y),
        .o_cloud_z    (o_cloud_z),
        .o_idx_x      (o_idx_x),
        .o_idx_y      (o_idx_y),
        .o_invalid    (o_invalid),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy)
    );

    // Coordinate = floor(((pix << FRAC) - c) * d * inv / 2^INV_FRAC), kept to OUT_W bits.
    function automatic logic [OUT_W-1:0] project(longint pix, longint c, longint d, longint inv);
        longint num, den, q;
        den = longint'(1) << INV_FRAC;
        num = ((pix << FRAC_W) - c) * d * inv;
        q   = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q[OUT_W-1:0];
    endfunction

    function automatic pt_t expect_point(int i);
        pt_t    p;
        int     px, py;
        longint d, zz;
        bit     bad;
        px  = i % int'(r_width);
        py  = i / int'(r_width);
        d   = longint'(pix_depth[i]);
        bad = (d == 0);
`ifdef IDX2CLOUD_RANGE_CHECK_EN
        if (d < longint'(r_depth_min) || d > longint'(r_depth_max)) bad = 1'b1;
`endif
        p.ix  = px[H_SIZE_BW-1:0];
        p.iy  = py[V_SIZE_BW-1:0];
        p.inv = bad;
        if (bad) begin
            p.x = '0;
            p.y = '0;
            p.z = '0;
        end else begin
            p.x = project(longint'(px), longint'(r_cx), d, longint'(r_inv_fx));
            p.y = project(longint'(py), longint'(r_cy), d, longint'(r_inv_fy));
            zz  = d * (longint'(1) << FRAC_W);
            p.z = zz[OUT_W-1:0];
        end
        return p;
    endfunction

    function automatic pt_t sample_out();
        pt_t p;
        p.x   = o_cloud_x;
        p.y   = o_cloud_y;
        p.z   = o_cloud_z;
        p.ix  = o_idx_x;
        p.iy  = o_idx_y;
        p.inv = o_invalid;
        return p;
    endfunction

    task automatic fill_depth(input int n, input bit random_mode, input int val);
        int rv;
        pix_depth.delete();
        for (int i = 0; i < n; i++) begin
            rv = random_mode ? int'($urandom_range(1, 65535)) : val;
            if (random_mode && $urandom_range(0, 9) == 0) rv = 0;
            pix_depth.push_back(rv[DEPTH_W-1:0]);
        end
    endtask

    // Runs one frame: pulses start, streams pix_depth, captures every handed-off point.
    task automatic applyStimulus(input int ready_low, input int valid_low, input int max_cyc);
        int  sent, total, cyc;
        bit  held;
        pt_t held_pt, cur;
        out_q.delete();
        acc_cyc = -1; out_cyc = -1; done_cnt = 0; hold_err = 0; extra_out = 0; timed_out = 0;
        total = int'(r_width) * int'(r_height);
        @(negedge clk);
        i_start = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        sent = 0; cyc = 0; held = 0; held_pt = '0;
        while (done_cnt == 0 && cyc < max_cyc) begin
            i_ready = ($urandom_range(0, 99) >= ready_low);
            i_valid = (sent < total) && ($urandom_range(0, 99) >= valid_low);
            i_depth = (sent < total) ? pix_depth[sent] : '0;
            #1;
            cur = sample_out();
            if (held && (!o_valid || cur !== held_pt)) hold_err++;
            held    = o_valid && !i_ready;
            held_pt = cur;
            if (o_valid && i_ready) begin
                out_q.push_back(cur);
                if (out_cyc < 0) out_cyc = cyc;
            end
            if (i_valid && o_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                sent++;
            end
            if (o_frame_done) done_cnt++;
            cyc++;
            @(negedge clk);
        end
        if (done_cnt == 0) timed_out = 1;
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (o_valid) extra_out++;
            if (o_frame_done) done_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({o_valid, o_ready, o_busy, o_frame_done, o_invalid, o_cloud_x, o_cloud_y, o_cloud_z, o_idx_x, o_idx_y} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b ready=%b busy=%b done=%b x=%h y=%h z=%h expected all zero",
                     o_valid, o_ready, o_busy, o_frame_done, o_cloud_x, o_cloud_y, o_cloud_z);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b expected 0 0", o_busy, o_ready);
        end
    endtask

    task automatic test_basic();
        pt_t e;
        r_width = 4; r_height = 2; r_cx = CX_BW'(2 << FRAC_W); r_cy = '0;
        r_inv_fx = INV_W'(1 << INV_FRAC); r_inv_fy = INV_W'(1 << INV_FRAC);
        fill_depth(8, 0, 10);
        applyStimulus(0, 0, 200);
        n_checks++;
        if (timed_out || out_q.size() != 8) begin
            n_errors++;
            $display("FAIL basic_count: got %0d points (timeout=%0d) expected 8", out_q.size(), timed_out);
        end
        for (int i = 0; i < out_q.size() && i < 8; i++) begin
            e = expect_point(i);
            n_checks++;
            if (out_q[i] !== e) begin
                n_errors++;
                $display("FAIL basic_pt%0d: got %h expected %h", i, out_q[i], e);
            end
        end
        n_checks++;
        if (out_q.size() > 0 && (int'(out_q[0].x) !== -5120 || out_q[0].z !== 32'd2560)) begin
            n_errors++;
            $display("FAIL basic_first_xz: got x=%0d z=%0d expected x=-5120 z=2560", int'(out_q[0].x), out_q[0].z);
        end
        n_checks++;
        if (out_cyc - acc_cyc !== 4) begin
            n_errors++;
            $display("FAIL basic_latency: got %0d cycles expected 4", out_cyc - acc_cyc);
        end
        n_checks++;
        if (done_cnt !== 1 || extra_out !== 0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_frame_done: got done=%0d extra=%0d busy=%b expected 1 0 0", done_cnt, extra_out, o_busy);
        end
    endtask

    task automatic test_floor();
        r_width = 1; r_height = 1; r_cy = CY_BW'(1 << FRAC_W);
        r_inv_fx = INV_W'(1 << (INV_FRAC - 1)); r_inv_fy = INV_W'(1 << INV_FRAC);
        fill_depth(1, 0, 5);
        r_cx = CX_BW'(3 << FRAC_W);
        applyStimulus(0, 0, 100);
        n_checks++;
        if (out_q.size() != 1 || int'(out_q[0].x) !== -1920 || int'(out_q[0].y) !== -1280) begin
            n_errors++;
            $display("FAIL floor_exact: got n=%0d x=%0d y=%0d expected n=1 x=-1920 y=-1280",
                     out_q.size(), int'(out_q[0].x), int'(out_q[0].y));
        end
        r_cx = CX_BW'((3 << FRAC_W) + 1);
        applyStimulus(0, 0, 100);
        n_checks++;
        if (out_q.size() != 1 || int'(out_q[0].x) !== -1923) begin
            n_errors++;
            $display("FAIL floor_round_down: got n=%0d x=%0d expected n=1 x=-1923", out_q.size(), int'(out_q[0].x));
        end
    endtask

    // Random geometry and calibration; ready_low/valid_low set the stall and bubble rates.
    task automatic test_random_stream(input int ready_low, input int valid_low, input int frames);
        pt_t e;
        int  w, h, total;
        for (int f = 0; f < frames; f++) begin
            w = $urandom_range(2, 8); h = $urandom_range(1, 4); total = w * h;
            r_width  = H_SIZE_BW'(w); r_height = V_SIZE_BW'(h);
            r_cx     = CX_BW'($urandom_range(0, 12 << FRAC_W));
            r_cy     = CY_BW'($urandom_range(0, 6 << FRAC_W));
            r_inv_fx = INV_W'($urandom_range(1, (1 << INV_W) - 1));
            r_inv_fy = INV_W'($urandom_range(1, (1 << INV_W) - 1));
            fill_depth(total, 1, 0);
            applyStimulus(ready_low, valid_low, 60 * total + 100);
            n_checks++;
            if (timed_out || out_q.size() != total || done_cnt !== 1 || extra_out !== 0) begin
                n_errors++;
                $display("FAIL stream_count f%0d: got n=%0d done=%0d extra=%0d timeout=%0d expected n=%0d done=1",
                         f, out_q.size(), done_cnt, extra_out, timed_out, total);
            end
            n_checks++;
            if (hold_err !== 0) begin
                n_errors++;
                $display("FAIL stream_hold f%0d: got %0d unstable stall cycles expected 0", f, hold_err);
            end
            for (int i = 0; i < out_q.size() && i < total; i++) begin
                e = expect_point(i);
                n_checks++;
                if (out_q[i] !== e) begin
                    n_errors++;
                    $display("FAIL stream_pt f%0d i%0d: got %h expected %h", f, i, out_q[i], e);
                end
            end
        end
    endtask

    task automatic test_zero_depth();
        pt_t e;
        r_width = 4; r_height = 2; r_cx = CX_BW'(1 << FRAC_W); r_cy = '0;
        r_inv_fx = INV_W'(1 << INV_FRAC); r_inv_fy = INV_W'(1 << INV_FRAC);
        fill_depth(8, 0, 7);
        pix_depth[1] = '0;
        applyStimulus(0, 0, 200);
        n_checks++;
        if (out_q.size() != 8 || out_q[1].inv !== 1'b1 || {out_q[1].x, out_q[1].y, out_q[1].z} !== '0
            || out_q[1].ix !== 1 || out_q[1].iy !== 0) begin
            n_errors++;
            $display("FAIL zero_depth_pt1: got n=%0d %h expected invalid point (1,0) with zero xyz", out_q.size(), out_q[1]);
        end
        for (int i = 0; i < 3 && i < out_q.size(); i += 2) begin
            e = expect_point(i);
            n_checks++;
            if (out_q[i] !== e || out_q[i].inv !== 1'b0) begin
                n_errors++;
                $display("FAIL zero_depth_neighbour%0d: got %h expected %h", i, out_q[i], e);
            end
        end
    endtask

    task automatic test_range();
        logic [2:0] got_inv, exp_inv;
        r_width = 3; r_height = 1; r_cx = '0; r_cy = '0;
        r_inv_fx = INV_W'(1 << INV_FRAC); r_inv_fy = INV_W'(1 << INV_FRAC);
        r_depth_min = 16'd100; r_depth_max = 16'd200;
        fill_depth(3, 0, 0);
        pix_depth[0] = 16'd50; pix_depth[1] = 16'd150; pix_depth[2] = 16'd250;
        applyStimulus(0, 0, 100);
`ifdef IDX2CLOUD_RANGE_CHECK_EN
        exp_inv = 3'b101;
`else
        exp_inv = 3'b000;
`endif
        got_inv = 3'bxxx;
        if (out_q.size() == 3) got_inv = {out_q[2].inv, out_q[1].inv, out_q[0].inv};
        n_checks++;
        if (got_inv !== exp_inv) begin
            n_errors++;
            $display("FAIL range_invalid: got %b expected %b (n=%0d)", got_inv, exp_inv, out_q.size());
        end
        n_checks++;
        if (out_q.size() == 3 && out_q[1].z !== 32'(150 << FRAC_W)) begin
            n_errors++;
            $display("FAIL range_inside_z: got %0d expected %0d", out_q[1].z, 150 << FRAC_W);
        end
        r_depth_min = '0; r_depth_max = '1;
    endtask

    task automatic test_reset_midrun();
        pt_t e;
        int  sent, cyc, stray;
        r_width = 5; r_height = 3; r_cx = CX_BW'(2 << FRAC_W); r_cy = CY_BW'(1 << FRAC_W);
        r_inv_fx = INV_W'(3 << (INV_FRAC - 2)); r_inv_fy = INV_W'(1 << INV_FRAC);
        fill_depth(15, 1, 0);
        @(negedge clk);
        i_start = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        sent = 0; cyc = 0;
        while (sent < 3 && cyc < 50) begin
            i_valid = 1'b1;
            i_depth = pix_depth[sent];
            #1;
            if (o_ready) sent++;
            cyc++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        n_checks++;
        if (sent != 3) begin
            n_errors++;
            $display("FAIL midrun_accepts: got %0d expected 3", sent);
        end
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_busy, o_frame_done, o_invalid, o_cloud_x, o_cloud_y, o_cloud_z, o_idx_x, o_idx_y} !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset_outputs: got valid=%b busy=%b done=%b x=%h expected all zero",
                     o_valid, o_busy, o_frame_done, o_cloud_x);
        end
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (o_frame_done || o_valid || o_busy) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_errors++;
            $display("FAIL midrun_no_done: got %0d stray activity cycles expected 0", stray);
        end
        applyStimulus(20, 0, 1000);
        n_checks++;
        if (timed_out || out_q.size() != 15 || done_cnt !== 1) begin
            n_errors++;
            $display("FAIL midrun_restart_count: got n=%0d done=%0d expected 15 1", out_q.size(), done_cnt);
        end
        for (int i = 0; i < out_q.size() && i < 15; i++) begin
            e = expect_point(i);
            n_checks++;
            if (out_q[i] !== e) begin
                n_errors++;
                $display("FAIL midrun_restart_pt%0d: got %h expected %h", i, out_q[i], e);
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_depth = '0;
        r_width = 1; r_height = 1; r_cx = '0; r_cy = '0; r_inv_fx = '0; r_inv_fy = '0;
        r_depth_min = '0; r_depth_max = '1;
        test_reset();
        test_basic();
        test_floor();
        test_random_stream(30, 0, 3);
        test_zero_depth();
        test_range();
        test_random_stream(30, 40, 2);
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
